image_cache_pp: RTL and testbench
=================================

IMAGE_CACHE_PP -- requirements
Module: image_cache_pp

Interface
REQ-001 The block SHALL have parameter ROW_SIZE, default supportedImageWidth, meaning pixels per image line.
REQ-002 The block SHALL have parameter COL_SIZE, default supportedImageHeight, meaning lines per frame.
REQ-003 The block SHALL have parameter WORD_SIZE, default inputImageDepth, meaning bits per channel sample.
REQ-004 The block SHALL have parameter CHANNELS, default 1, meaning samples per pixel.
REQ-005 The block SHALL take one clock and a synchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  synchronous active-low reset.
REQ-006 The block SHALL have the write ports: wr_valid  in  1  write beat offered; wr_ready  out  1  write beat accepted; wr_sof  in  1  beat is pixel (0,0); wr_data  in  CHANNELS*WORD_SIZE  pixel, channel 0 in LSBs.
REQ-007 The block SHALL have the read ports: rd_req  in  1  read request; rd_x  in  X_WIDTH  column; rd_y  in  Y_WIDTH  line; rd_valid  out  1  rd_data valid; rd_data  out  CHANNELS*WORD_SIZE  pixel read.
REQ-008 The block SHALL have the frame ports: frame_avail  out  1  complete frame readable; rd_release  in  1  reader finished with frame.

Function
REQ-009 Storage SHALL be two banks (ping-pong), each WORDS = ROW_SIZE*COL_SIZE words of CHANNELS*WORD_SIZE bits; address = y*ROW_SIZE + x.
REQ-010 A write beat SHALL be accepted when wr_valid && wr_ready, and stored at the write pointer in the write bank; the pointer then increments.
REQ-011 An accepted beat with wr_sof=1 SHALL be stored at address 0 and set the pointer to 1, discarding any partial frame.
REQ-012 The accepted beat at address WORDS-1 SHALL complete the frame and reset the pointer to 0.
REQ-013 The control FSM SHALL have the states EMPTY (no full bank), ONE_FULL (read bank full, other bank filling) and BOTH_FULL.
REQ-014 Frame completion in EMPTY SHALL swap the banks and move to ONE_FULL.
REQ-015 Frame completion in ONE_FULL SHALL move to BOTH_FULL with no swap.
REQ-016 rd_release in ONE_FULL SHALL move to EMPTY.
REQ-017 rd_release in BOTH_FULL SHALL swap the banks and move to ONE_FULL.
REQ-018 Frame completion and rd_release in the same cycle in ONE_FULL SHALL swap the banks and stay in ONE_FULL; frame_avail SHALL stay 1.
REQ-019 rd_release in EMPTY SHALL be ignored.
REQ-020 wr_ready SHALL be 0 in BOTH_FULL and 1 in the other states (combinational from the state).
REQ-021 frame_avail SHALL be 1 in ONE_FULL and BOTH_FULL (registered state decode).
REQ-022 A read SHALL have 1-cycle latency: rd_req with frame_avail=1 gives rd_valid=1 and rd_data from the read bank on the next cycle.
REQ-023 rd_req with frame_avail=0 SHALL give rd_valid=0 next cycle, and rd_data SHALL hold its value.
REQ-024 A read with rd_x>=ROW_SIZE or rd_y>=COL_SIZE SHALL give rd_valid=1 and rd_data=0.
REQ-025 A read in the same cycle as a swap SHALL use the pre-swap read bank.
REQ-026 The write and read paths SHALL operate concurrently on different banks with no cross-bank hazard.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL set state=EMPTY, write bank=0, write pointer=0, rd_valid=0, rd_data=0, frame_avail=0.
REQ-028 Reset asserted mid-frame SHALL discard all stored frames; RAM contents need not be cleared.
REQ-029 wr_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after reset.

Structure
REQ-030 Package pkg_image_cache_pp SHALL hold the ROW_SIZE/COL_SIZE defaults, derived X_WIDTH=clog2(ROW_SIZE), Y_WIDTH=clog2(COL_SIZE), ADDR_WIDTH=clog2(WORDS), the FSM state typedef, and the pixel word typedef.
REQ-031 One sub-module, image_cache_bank (1 write port, 1 registered read port, 1-cycle latency), SHALL be instantiated twice; the FSM and pointer logic SHALL stay in image_cache_pp.

Verification (ROW_SIZE=4, COL_SIZE=3, WORD_SIZE=8, CHANNELS=2, WORDS=12)
REQ-032 Write 12 beats 0x0100..0x010B with sof on the first -> frame_avail=1 the cycle after the 12th beat; read (x=3,y=2) -> rd_data=0x010B one cycle later.
REQ-033 Write frame A then frame B with no release -> wr_ready=0 after B's 12th beat; rd_release -> wr_ready=1, and read (0,0) returns B's first pixel.
REQ-034 Complete the frame and pulse rd_release in the same cycle from ONE_FULL -> frame_avail stays 1; the next read returns the new frame's data.
REQ-035 Write 5 beats, then a sof beat, then 11 more beats -> frame completes after 12 beats counted from the sof; address 0 holds the sof data.
REQ-036 Read (x=4,y=0) -> rd_valid=1, rd_data=0; rd_req while frame_avail=0 -> rd_valid=0.
REQ-037 Assert rst_n=0 during BOTH_FULL -> frame_avail=0, rd_valid=0, rd_data=0, wr_ready=1 after release; a new 12-beat frame completes normally.

Source files
------------

// File: rtl/image_cache_pp_pkg.sv
// Shared defaults, FSM state type and pixel word type for the ping-pong image cache.
package pkg_image_cache_pp;

   localparam int SUPPORTED_IMAGE_WIDTH  = 640;
   localparam int SUPPORTED_IMAGE_HEIGHT = 480;
   localparam int INPUT_IMAGE_DEPTH      = 8;

   // Coordinate width can also hold the dimension itself, so a read at x==ROW_SIZE
   // is expressible and lands in the out-of-range path.
   function automatic int coord_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   localparam int X_WIDTH    = coord_width(SUPPORTED_IMAGE_WIDTH);
   localparam int Y_WIDTH    = coord_width(SUPPORTED_IMAGE_HEIGHT);
   localparam int ADDR_WIDTH = $clog2(SUPPORTED_IMAGE_WIDTH * SUPPORTED_IMAGE_HEIGHT);

   typedef enum logic [1:0] {EMPTY, ONE_FULL, BOTH_FULL} state_t;

   typedef logic [INPUT_IMAGE_DEPTH-1:0] pixel_t;

endpackage

// File: rtl/image_cache_pp_bank.sv
// One frame bank: single write port, registered read port with 1-cycle latency.
module image_cache_bank #(
   parameter int DEPTH  = 12,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/image_cache_pp.sv
// Ping-pong frame cache: one bank fills from the write stream while the other is read randomly.
module image_cache_pp
   import pkg_image_cache_pp::*;
#(
   parameter int ROW_SIZE  = SUPPORTED_IMAGE_WIDTH,
   parameter int COL_SIZE  = SUPPORTED_IMAGE_HEIGHT,
   parameter int WORD_SIZE = INPUT_IMAGE_DEPTH,
   parameter int CHANNELS  = 1,
   localparam int X_W      = coord_width(ROW_SIZE),
   localparam int Y_W      = coord_width(COL_SIZE),
   localparam int DW       = CHANNELS * WORD_SIZE
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic           wr_sof,
   input  logic [DW-1:0]  wr_data,
   input  logic           rd_req,
   input  logic [X_W-1:0] rd_x,
   input  logic [Y_W-1:0] rd_y,
   output logic           rd_valid,
   output logic [DW-1:0]  rd_data,
   output logic           frame_avail,
   input  logic           rd_release
);

   localparam int WORDS = ROW_SIZE * COL_SIZE;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t               state;
   logic                 wr_bank;
   logic [AW-1:0]        wr_ptr;
   logic                 rd_sel_q, rd_zero_q;
   logic [1:0][DW-1:0]   bank_q;

   logic                 wr_accept, wr_last, rd_oob, rd_en, rd_bank;
   logic [AW-1:0]        wr_addr, rd_addr;

   assign wr_ready  = rst_n && (state != BOTH_FULL);
   assign wr_accept = wr_valid && wr_ready;
   assign wr_addr   = wr_sof ? '0 : wr_ptr;
   assign wr_last   = wr_accept && (wr_addr == AW'(WORDS - 1));

   assign rd_bank = ~wr_bank;
   assign rd_oob  = (int'(rd_x) >= ROW_SIZE) || (int'(rd_y) >= COL_SIZE);
   assign rd_addr = AW'(int'(rd_y) * ROW_SIZE + int'(rd_x));
   assign rd_en   = rd_req && frame_avail && !rd_oob;

   for (genvar i = 0; i < 2; i++) begin : g_bank
      image_cache_bank #(.DEPTH(WORDS), .DATA_W(DW), .ADDR_W(AW)) u_bank (
         .clk   (clk),
         .we    (wr_accept && (wr_bank == 1'(i))),
         .waddr (wr_addr),
         .wdata (wr_data),
         .re    (rd_en && (rd_bank == 1'(i))),
         .raddr (rd_addr),
         .rdata (bank_q[i])
      );
   end

   // Bank read registers are not reset; rd_zero_q masks them after reset and for out-of-range reads.
   assign rd_data = rd_zero_q ? '0 : bank_q[rd_sel_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= EMPTY;
         wr_bank     <= 1'b0;
         wr_ptr      <= '0;
         rd_valid    <= 1'b0;
         frame_avail <= 1'b0;
         rd_zero_q   <= 1'b1;
         rd_sel_q    <= 1'b0;
      end else begin
         rd_valid <= rd_req && frame_avail;
         if (rd_req && frame_avail) begin
            rd_zero_q <= rd_oob;
            rd_sel_q  <= rd_bank;
         end
         if (wr_accept) wr_ptr <= wr_last ? '0 : wr_addr + 1'b1;
         case (state)
            EMPTY: if (wr_last) begin
               wr_bank     <= ~wr_bank;
               state       <= ONE_FULL;
               frame_avail <= 1'b1;
            end
            ONE_FULL: begin
               if (wr_last && rd_release) wr_bank <= ~wr_bank;
               else if (wr_last) state <= BOTH_FULL;
               else if (rd_release) begin
                  state       <= EMPTY;
                  frame_avail <= 1'b0;
               end
            end
            BOTH_FULL: if (rd_release) begin
               wr_bank <= ~wr_bank;
               state   <= ONE_FULL;
            end
            default: begin
               state       <= EMPTY;
               frame_avail <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_cache_pp.sv
// Bench for image_cache_pp: directed scenarios plus random traffic against a frame-queue model.
module tb_image_cache_pp;

   localparam int RS = 4, CS = 3, WS = 8, CH = 2, WORDS = RS * CS, DW = WS * CH;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          wr_valid = 1'b0, wr_sof = 1'b0, rd_req = 1'b0, rd_release = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [2:0]    rd_x = '0;
   logic [1:0]    rd_y = '0;
   logic          wr_ready, rd_valid, frame_avail;
   logic [DW-1:0] rd_data;

   always #5 clk = ~clk;

   image_cache_pp #(.ROW_SIZE(RS), .COL_SIZE(CS), .WORD_SIZE(WS), .CHANNELS(CH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sof(wr_sof),
      .wr_data(wr_data), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
      .rd_data(rd_data), .frame_avail(frame_avail), .rd_release(rd_release)
   );

   // Model: queue of complete frames (oldest is readable), a partial frame and its fill index.
   typedef logic [DW-1:0] frame_t [WORDS];
   frame_t        fq[$];
   frame_t        cur;
   int            wptr;
   logic          exp_valid;
   logic [DW-1:0] exp_data;
   int            n_cmp = 0, n_bad = 0;

   task automatic cycle();
      bit avail, done;
      int a;
      @(posedge clk);
      done = 1'b0;
      if (!rst_n) begin
         fq.delete(); wptr = 0; exp_valid = 1'b0; exp_data = '0;
      end else begin
         avail = fq.size() > 0;
         exp_valid = rd_req && avail;
         if (rd_req && avail)
            exp_data = (int'(rd_x) >= RS || int'(rd_y) >= CS) ? '0 : fq[0][int'(rd_y) * RS + int'(rd_x)];
         if (wr_valid && fq.size() < 2) begin
            a = wr_sof ? 0 : wptr;
            cur[a] = wr_data;
            done = (a == WORDS - 1);
            wptr = done ? 0 : a + 1;
         end
         if (rd_release && avail) void'(fq.pop_front());
         if (done) fq.push_back(cur);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
   endtask

   task automatic write_beat(input logic [DW-1:0] d, input bit sof, input bit rel);
      wr_valid = 1'b1; wr_data = d; wr_sof = sof; rd_release = rel;
      cycle();
      wr_valid = 1'b0; wr_sof = 1'b0; rd_release = 1'b0;
   endtask

   task automatic write_frame(input logic [DW-1:0] base);
      for (int i = 0; i < WORDS; i++) write_beat(base + DW'(i), i == 0, 1'b0);
   endtask

   task automatic read_px(input int x, input int y);
      rd_req = 1'b1; rd_x = 3'(x); rd_y = 2'(y);
      cycle();
      rd_req = 1'b0;
   endtask

   task automatic release_frame();
      rd_release = 1'b1;
      cycle();
      rd_release = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycle();
      n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      n_cmp++; if (frame_avail !== 1'b0) begin n_bad++; $display("FAIL reset_avail: got %b want 0", frame_avail); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
   endtask

   task automatic test_basic_frame();
      do_reset();
      write_frame(16'h0100);
      n_cmp++; if (frame_avail !== 1'b1) begin n_bad++; $display("FAIL basic_avail: got %b want 1", frame_avail); end
      read_px(3, 2);
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rd_valid: got %b want 1", rd_valid); end
      n_cmp++; if (rd_data !== 16'h010B) begin n_bad++; $display("FAIL basic_rd_data: got %h want 010b", rd_data); end
   endtask

   task automatic test_both_full();
      do_reset();
      write_frame(16'h0A00);
      write_frame(16'h0B00);
      n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL both_full_wr_ready: got %b want 0", wr_ready); end
      release_frame();
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL release_wr_ready: got %b want 1", wr_ready); end
      read_px(0, 0);
      n_cmp++; if (rd_data !== 16'h0B00) begin n_bad++; $display("FAIL both_full_read: got %h want 0b00", rd_data); end
   endtask

   task automatic test_complete_release();
      do_reset();
      write_frame(16'h0A00);
      for (int i = 0; i < WORDS - 1; i++) write_beat(16'h0B00 + DW'(i), i == 0, 1'b0);
      write_beat(16'h0B0B, 1'b0, 1'b1);
      n_cmp++; if (frame_avail !== 1'b1) begin n_bad++; $display("FAIL cr_avail: got %b want 1", frame_avail); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL cr_wr_ready: got %b want 1", wr_ready); end
      read_px(1, 1);
      n_cmp++; if (rd_data !== 16'h0B05) begin n_bad++; $display("FAIL cr_read: got %h want 0b05", rd_data); end
   endtask

   task automatic test_sof_restart();
      do_reset();
      for (int i = 0; i < 5; i++) write_beat(16'h0500 + DW'(i), i == 0, 1'b0);
      write_beat(16'h0C00, 1'b1, 1'b0);
      for (int i = 1; i < WORDS - 1; i++) write_beat(16'h0C00 + DW'(i), 1'b0, 1'b0);
      n_cmp++; if (frame_avail !== 1'b0) begin n_bad++; $display("FAIL sof_early_avail: got %b want 0", frame_avail); end
      write_beat(16'h0C0B, 1'b0, 1'b0);
      n_cmp++; if (frame_avail !== 1'b1) begin n_bad++; $display("FAIL sof_avail: got %b want 1", frame_avail); end
      read_px(0, 0);
      n_cmp++; if (rd_data !== 16'h0C00) begin n_bad++; $display("FAIL sof_addr0: got %h want 0c00", rd_data); end
      read_px(3, 2);
      n_cmp++; if (rd_data !== 16'h0C0B) begin n_bad++; $display("FAIL sof_last: got %h want 0c0b", rd_data); end
   endtask

   task automatic test_out_of_range();
      read_px(4, 0);
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL oob_valid: got %b want 1", rd_valid); end
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL oob_data: got %h want 0", rd_data); end
      read_px(2, 0);
      n_cmp++; if (rd_data !== 16'h0C02) begin n_bad++; $display("FAIL oob_after: got %h want 0c02", rd_data); end
      release_frame();
      read_px(1, 0);
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL noavail_valid: got %b want 0", rd_valid); end
      n_cmp++; if (rd_data !== 16'h0C02) begin n_bad++; $display("FAIL noavail_hold: got %h want 0c02", rd_data); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      write_frame(16'h0A00);
      write_frame(16'h0B00);
      read_px(1, 0);
      n_cmp++; if (rd_data !== 16'h0A01) begin n_bad++; $display("FAIL mid_pre_read: got %h want 0a01", rd_data); end
      rst_n = 1'b0;
      cycle();
      n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_wr_ready: got %b want 0", wr_ready); end
      cycle();
      rst_n = 1'b1;
      cycle();
      n_cmp++; if (frame_avail !== 1'b0) begin n_bad++; $display("FAIL mid_avail: got %b want 0", frame_avail); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
      n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL mid_rd_data: got %h want 0", rd_data); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL mid_wr_ready: got %b want 1", wr_ready); end
      write_frame(16'h0D00);
      n_cmp++; if (frame_avail !== 1'b1) begin n_bad++; $display("FAIL mid_new_avail: got %b want 1", frame_avail); end
      read_px(2, 1);
      n_cmp++; if (rd_data !== 16'h0D06) begin n_bad++; $display("FAIL mid_new_read: got %h want 0d06", rd_data); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         wr_valid   = ($urandom_range(0, 9) < 7);
         wr_sof     = ($urandom_range(0, 39) == 0);
         wr_data    = DW'($urandom);
         rd_req     = $urandom_range(0, 1);
         rd_x       = 3'($urandom_range(0, 4));
         rd_y       = 2'($urandom_range(0, 3));
         rd_release = ($urandom_range(0, 19) == 0);
         cycle();
         n_cmp++; if (frame_avail !== (fq.size() > 0)) begin n_bad++; $display("FAIL rnd_avail c=%0d: got %b want %b", c, frame_avail, fq.size() > 0); end
         n_cmp++; if (wr_ready !== (fq.size() < 2)) begin n_bad++; $display("FAIL rnd_wr_ready c=%0d: got %b want %b", c, wr_ready, fq.size() < 2); end
         n_cmp++; if (rd_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_rd_valid c=%0d: got %b want %b", c, rd_valid, exp_valid); end
         n_cmp++; if (rd_data !== exp_data) begin n_bad++; $display("FAIL rnd_rd_data c=%0d: got %h want %h", c, rd_data, exp_data); end
      end
      wr_valid = 1'b0; wr_sof = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_both_full();
      test_complete_release();
      test_sof_restart();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
